// File: rtl/pc_gen_if.sv
// Fetch-side bundle for the program-counter unit: redirect requests,
// handshake/decode sideband from fetch, and the registered PC outputs.
interface pc_gen_if #(
  parameter int XLEN = 32,
  parameter int CW   = 3
);
  logic            trap;
  logic [XLEN-1:0] trap_addr;
  logic            jump;
  logic [XLEN-1:0] jump_addr;
  logic            pause;
  logic            fetch_ready;
  logic            inst_len2;
  logic            is_call;
  logic            is_ret;
  logic [XLEN-1:0] out;
  logic            out_valid;
  logic [CW-1:0]   ras_count;

  // Driver side: pipeline control and fetch path
  modport master (
    output trap, trap_addr, jump, jump_addr, pause, fetch_ready,
           inst_len2, is_call, is_ret,
    input  out, out_valid, ras_count
  );

  // PC generator side
  modport slave (
    input  trap, trap_addr, jump, jump_addr, pause, fetch_ready,
           inst_len2, is_call, is_ret,
    output out, out_valid, ras_count
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential stepping by
// 2 or 4 bytes, trap/jump redirects, and return prediction through a
// circular return-address stack. All outputs come straight from flops.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] START_ADDR = '0,
  parameter int              RAS_DEPTH  = 4,
  parameter bit              C_EXT      = 1'b1
) (
  input logic   clk,
  input logic   rst,
  pc_gen_if.slave bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  // Redirect targets must be instruction aligned: halfword with the
  // compressed extension, word without it.
  localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? {{(XLEN-1){1'b1}}, 1'b0}
                                                 : {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic            ras_we;
  logic [PW-1:0]   ras_widx;

  logic            fire;
  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] top;
  logic [PW-1:0]   top_idx;
  logic            ras_full;
  logic            ras_empty;

  assign fire      = (state_q == ST_RUN) & bus.fetch_ready & ~bus.pause;
  assign seq       = pc_q + ((C_EXT && bus.inst_len2) ? XLEN'(2) : XLEN'(4));
  assign top_idx   = ptr_q - PW'(1);
  assign top       = ras[top_idx];
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
  assign ras_empty = (cnt_q == '0);

  // Next-PC selection by priority, plus the RAS pointer/count bookkeeping.
  // ptr_q always points at the slot the next push writes, so the top of
  // stack sits one below it and a full stack simply overwrites the oldest.
  always_comb begin
    state_d  = ST_RUN;
    pc_d     = pc_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = ptr_q;
    if (state_q == ST_RUN) begin
      if (bus.trap) begin
        pc_d  = bus.trap_addr & ALIGN_MASK;
        ptr_d = '0;
        cnt_d = '0;
      end else if (bus.jump) begin
        pc_d = bus.jump_addr & ALIGN_MASK;
      end else if (fire) begin
        pc_d = seq;
        unique case ({bus.is_call, bus.is_ret})
          2'b10: begin
            ras_we = 1'b1;
            ptr_d  = ptr_q + PW'(1);
            if (!ras_full) cnt_d = cnt_q + CW'(1);
          end
          2'b01: begin
            if (!ras_empty) begin
              pc_d  = top;
              ptr_d = top_idx;
              cnt_d = cnt_q - CW'(1);
            end
          end
          2'b11: begin
            if (!ras_empty) begin
              pc_d     = top;
              ras_we   = 1'b1;
              ras_widx = top_idx;
            end else begin
              ras_we = 1'b1;
              ptr_d  = ptr_q + PW'(1);
              cnt_d  = cnt_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Control state, PC and RAS occupancy with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAS storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (ras_we) ras[ras_widx] <= seq;
  end

  assign bus.out       = pc_q;
  assign bus.out_valid = (state_q == ST_RUN);
  assign bus.ras_count = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes hand-computed expected
// PC/valid/count per cycle, a monitor pops and compares after each edge.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_gen_if #(.XLEN(32), .CW(3)) bus ();
  pc_gen_if #(.XLEN(32), .CW(3)) bus0 ();

  pc_gen #(.XLEN(32), .START_ADDR(32'h0), .RAS_DEPTH(4), .C_EXT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_gen #(.XLEN(32), .START_ADDR(32'h0), .RAS_DEPTH(4), .C_EXT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic        valid;
    logic [2:0]  cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name,
                             input logic [31:0] ao, input logic [31:0] eo,
                             input logic av, input logic ev,
                             input logic [2:0] ac, input logic [2:0] ec);
    checks++;
    if (ao !== eo || av !== ev || ac !== ec) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h valid=%b ras_count=%0d, expected out=%h valid=%b ras_count=%0d",
               name, ao, av, ac, eo, ev, ec);
    end
  endtask

  task automatic applyStimulus(input string name,
                               input logic tr, input logic [31:0] ta,
                               input logic jp, input logic [31:0] ja,
                               input logic ps, input logic fr,
                               input logic l2, input logic cl, input logic rt,
                               input logic [31:0] eo, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    bus.trap        = tr;
    bus.trap_addr   = ta;
    bus.jump        = jp;
    bus.jump_addr   = ja;
    bus.pause       = ps;
    bus.fetch_ready = fr;
    bus.inst_len2   = l2;
    bus.is_call     = cl;
    bus.is_ret      = rt;
    e.out = eo; e.valid = 1'b1; e.cnt = ec; e.name = name;
    q.push_back(e);
  endtask

  task automatic doFire(input string name, input logic l2, input logic cl,
                        input logic rt, input logic [31:0] eo, input logic [2:0] ec);
    applyStimulus(name, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, l2, cl, rt, eo, ec);
  endtask

  task automatic doJump(input string name, input logic [31:0] addr,
                        input logic [31:0] eo, input logic [2:0] ec);
    applyStimulus(name, 1'b0, 32'h0, 1'b1, addr, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, eo, ec);
  endtask

  // Monitor: one expected entry per clock edge once stimulus is running
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      checkOutput(e.name, bus.out, e.out, bus.out_valid, e.valid, bus.ras_count, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    bus.trap = 0; bus.trap_addr = 0; bus.jump = 0; bus.jump_addr = 0;
    bus.pause = 0; bus.fetch_ready = 1; bus.inst_len2 = 0;
    bus.is_call = 0; bus.is_ret = 0;
    bus0.trap = 0; bus0.trap_addr = 0; bus0.jump = 0; bus0.jump_addr = 0;
    bus0.pause = 0; bus0.fetch_ready = 1; bus0.inst_len2 = 0;
    bus0.is_call = 0; bus0.is_ret = 0;

    #1;
    checkOutput("reset_state", bus.out, 32'h0, bus.out_valid, 1'b0, bus.ras_count, 3'd0);

    // First start-up, then move to 0x100 to exercise a mid-run reset
    @(negedge clk);
    rst = 1'b0;
    e.out = 32'h0; e.valid = 1'b1; e.cnt = 3'd0; e.name = "startup_first";
    q.push_back(e);
    doJump("goto_100", 32'h100, 32'h100, 3'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", bus.out, 32'h0, bus.out_valid, 1'b0, bus.ras_count, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    e.out = 32'h0; e.valid = 1'b1; e.cnt = 3'd0; e.name = "startup";
    q.push_back(e);
    doFire("seq_4", 1'b0, 1'b0, 1'b0, 32'h4, 3'd0);
    doFire("seq_8", 1'b0, 1'b0, 1'b0, 32'h8, 3'd0);

    // Stepping with mixed lengths, stall, and wrap-around
    doJump("goto_10", 32'h10, 32'h10, 3'd0);
    doFire("len2_12", 1'b1, 1'b0, 1'b0, 32'h12, 3'd0);
    doFire("len4_16", 1'b0, 1'b0, 1'b0, 32'h16, 3'd0);
    doFire("len2_18", 1'b1, 1'b0, 1'b0, 32'h18, 3'd0);
    applyStimulus("pause_hold", 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h18, 3'd0);
    applyStimulus("notready_hold", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h18, 3'd0);
    doJump("goto_top", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 3'd0);
    doFire("wrap", 1'b0, 1'b0, 1'b0, 32'h0, 3'd0);

    // Redirect priority: trap beats jump and pause, and flushes the RAS
    doFire("call_at_0", 1'b0, 1'b1, 1'b0, 32'h4, 3'd1);
    applyStimulus("trap_over_jump", 1'b1, 32'h8000_0000, 1'b1, 32'h200,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'd0);
    doJump("jump_align", 32'h203, 32'h202, 3'd0);

    // Single call/return
    doJump("goto_100b", 32'h100, 32'h100, 3'd0);
    doFire("call_100", 1'b0, 1'b1, 1'b0, 32'h104, 3'd1);
    doJump("goto_400", 32'h400, 32'h400, 3'd1);
    doFire("ret_104", 1'b0, 1'b0, 1'b1, 32'h104, 3'd0);

    // Nested calls
    doJump("goto_100c", 32'h100, 32'h100, 3'd0);
    doFire("ncall_100", 1'b0, 1'b1, 1'b0, 32'h104, 3'd1);
    doJump("goto_200", 32'h200, 32'h200, 3'd1);
    doFire("ncall_200", 1'b0, 1'b1, 1'b0, 32'h204, 3'd2);
    doFire("nret_204", 1'b0, 1'b0, 1'b1, 32'h204, 3'd1);
    doFire("nret_104", 1'b0, 1'b0, 1'b1, 32'h104, 3'd0);

    // Overflow: five calls into a four-deep stack, then five returns
    for (int i = 0; i < 5; i++) begin
      logic [31:0] base;
      logic [2:0]  c;
      base = 32'(i) * 32'h10;
      c    = (i < 3) ? 3'(i + 1) : 3'd4;
      doJump("ovf_jump", base, base, (i == 0) ? 3'd0 : 3'(i > 4 ? 4 : i));
      doFire("ovf_call", 1'b0, 1'b1, 1'b0, base + 32'h4, c);
    end
    doFire("ovf_ret_44", 1'b0, 1'b0, 1'b1, 32'h44, 3'd3);
    doFire("ovf_ret_34", 1'b0, 1'b0, 1'b1, 32'h34, 3'd2);
    doFire("ovf_ret_24", 1'b0, 1'b0, 1'b1, 32'h24, 3'd1);
    doFire("ovf_ret_14", 1'b0, 1'b0, 1'b1, 32'h14, 3'd0);
    doFire("underflow", 1'b0, 1'b0, 1'b1, 32'h18, 3'd0);

    // Call and return together with a non-empty stack
    doJump("goto_100d", 32'h100, 32'h100, 3'd0);
    doFire("cr_setup", 1'b0, 1'b1, 1'b0, 32'h104, 3'd1);
    doJump("goto_300", 32'h300, 32'h300, 3'd1);
    doFire("callret_104", 1'b0, 1'b1, 1'b1, 32'h104, 3'd1);
    doJump("goto_500", 32'h500, 32'h500, 3'd1);
    doFire("ret_304", 1'b0, 1'b0, 1'b1, 32'h304, 3'd0);

    // Call together with a jump does not push
    applyStimulus("call_jump", 0, 0, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h600, 3'd0);
    doFire("ret_after_cj", 1'b0, 1'b0, 1'b1, 32'h604, 3'd0);

    // Return while fetch is not ready: nothing moves
    doFire("call_604", 1'b0, 1'b1, 1'b0, 32'h608, 3'd1);
    applyStimulus("ret_notready", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h608, 3'd1);
    doFire("ret_608", 1'b0, 1'b0, 1'b1, 32'h608, 3'd0);

    // Call and return together with an empty stack
    doFire("callret_empty", 1'b0, 1'b1, 1'b1, 32'h60C, 3'd1);
    doFire("ret_60c", 1'b0, 1'b0, 1'b1, 32'h60C, 3'd0);

    // Word-only variant masks both low target bits
    @(negedge clk);
    bus.jump = 1'b0; bus.is_call = 1'b0; bus.is_ret = 1'b0;
    bus0.jump = 1'b1; bus0.jump_addr = 32'h203;
    @(posedge clk); #3;
    checkOutput("noc_jump_align", bus0.out, 32'h200, bus0.out_valid, 1'b1, bus0.ras_count, 3'd0);
    bus0.jump = 1'b0;

    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      @(posedge clk); #3;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program-counter unit for the fetch stage.
- Produces the fetch address with a valid/ready handshake to the instruction-fetch path.
- Advances sequentially by 2 or 4 bytes, with optional compressed-instruction support.
- Accepts prioritised redirects (trap, jump) and predicts return targets through an internal return-address stack (RAS).

Parameters:
- XLEN, 32: address width in bits.
- START_ADDR, 32'h0000_0000: fetch address after reset.
- RAS_DEPTH, 4: number of return-address-stack entries; power of two, at least 2.
- C_EXT, 1: 1 enables 2-byte instruction steps; 0 means 4-byte steps only.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- trap  input  1  trap redirect request.
- trap_addr  input  XLEN  trap target.
- jump  input  1  jump/mispredict redirect request from execute.
- jump_addr  input  XLEN  jump target.
- pause  input  1  pipeline stall; holds the PC.
- fetch_ready  input  1  fetch path accepts the current address.
- inst_len2  input  1  instruction at out is 2 bytes; valid on fire only.
- is_call  input  1  instruction at out is a call; valid on fire only.
- is_ret  input  1  instruction at out is a return; valid on fire only.
- out  output  XLEN  current fetch address.
- out_valid  output  1  out is a valid fetch request.
- ras_count  output  $clog2(RAS_DEPTH)+1  number of occupied RAS entries.

Behaviour:
- Reset (async, any time, including mid-operation):
  - out = START_ADDR, out_valid = 0, ras_count = 0.
  - RAS pointer = 0. RAS entry contents are don't-care.
- Start-up: on the first rising clk after rst deasserts, out_valid goes to 1 and out holds START_ADDR. out_valid stays 1 until the next reset.
- Definitions:
  - fire = out_valid & fetch_ready & ~pause.
  - len = 2 if (C_EXT==1 and inst_len2==1), otherwise 4.
  - seq = (out + len) mod 2^XLEN; wrap-around is silent.
- Target alignment: bit 0 of trap_addr and jump_addr is forced to 0. When C_EXT==0, bits [1:0] are forced to 0.
- Next-PC priority, evaluated at each rising clk while out_valid==1:
  1. trap: out <= trap_addr. The RAS is flushed (ras_count <= 0). Applies regardless of pause or fetch_ready.
  2. jump: out <= jump_addr. The RAS is unchanged. Applies regardless of pause or fetch_ready.
  3. fire & is_ret & ras_count>0: out <= RAS top (predicted return).
  4. fire (all other cases): out <= seq.
  5. No fire: out holds.
- Redirect behaviour:
  - Redirects take effect in one cycle: out shows the new address on the clk edge following assertion.
  - trap or jump asserted while out_valid==0 is ignored.
- RAS updates happen on fire only, and only when neither trap nor jump is asserted:
  - is_call only: push seq. If ras_count==RAS_DEPTH, the oldest entry is overwritten and ras_count saturates at RAS_DEPTH.
  - is_ret only, ras_count>0: pop; ras_count decrements.
  - is_ret only, ras_count==0: underflow. out <= seq, and ras_count stays 0.
  - is_call & is_ret together, ras_count>0: the next PC is the old top, and the top entry is replaced with seq; ras_count is unchanged.
  - is_call & is_ret together, ras_count==0: out <= seq, then push seq.
- Inputs sampled only on fire: inst_len2, is_call and is_ret are ignored when fire==0.
- Storage: the RAS is a circular buffer, with the pointer wrapping modulo RAS_DEPTH.
- Outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset and start-up: assert rst mid-run with out=0x0000_0100. Require out=0 and out_valid=0 immediately (async). Release rst: out_valid=1 after 1 clk; with fire each cycle, out steps 0x0, 0x4, 0x8.
- Stepping, stall and width: C_EXT=1, inst_len2 pattern 1,0,1 from 0x10 gives 0x12, 0x16, 0x18. pause=1 or fetch_ready=0 holds 0x18. From out=0xFFFF_FFFC with len 4, out wraps to 0x0000_0000.
- Redirect priority:
  - trap=1 (trap_addr=0x8000_0000) with jump=1 (jump_addr=0x200) and pause=1: out=0x8000_0000, ras_count=0.
  - jump_addr=0x203 alone: out=0x202. With C_EXT=0, jump_addr=0x203 gives out=0x200.
- Call/return: call at 0x100 (len 4), jump to 0x400, ret fire → out=0x104. Nested calls at 0x100 and 0x200 return 0x204 then 0x104; ras_count ends at 0.
- RAS overflow/underflow: RAS_DEPTH=4, 5 calls from 0x0, 0x10, 0x20, 0x30, 0x40 → ras_count=4. Returns yield 0x44, 0x34, 0x24, 0x14. A fifth ret with ras_count=0 goes sequential, and ras_count stays 0.
- Corner combos:
  - is_call & is_ret at 0x300 with top 0x104: out=0x104, and top becomes 0x304.
  - is_call with jump the same cycle: no push.
  - is_ret with fetch_ready=0: no pop, out holds.
